// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit sitting between execute and data memory.
//
// Takes the ALU result as the effective address and rs2 as store data, runs a
// single req/ack transaction on the data bus, aligns and extends load data,
// and returns a one-cycle writeback pulse. The pipeline is held off through
// ex_ready while an op is in flight. Misaligned, illegal and bus faults are
// reported as a one-cycle pulse with a cause code.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   -> REQ is abandoned with a bus fault after WAIT_MAX cycles
//                without mem_ack (WAIT_MAX = 0 disables the timeout).
//   undefined -> no wait counter; REQ waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid / ex_ready   handshake with the execute stage
//   is_load, is_store     operation kind
//   funct3                width / signedness select
//   addr, wdata, rd       effective address, store data, load destination
//   mem_req, mem_we       bus request and write enable
//   mem_addr              word-aligned bus address
//   mem_wstrb, mem_wdata  byte enables and lane-replicated store data
//   mem_ack, mem_err      transaction complete, bus error (valid with ack)
//   mem_rdata             read word (valid with ack)
//   wb_valid, wb_rd       one-cycle load writeback pulse and destination
//   wb_data               aligned, extended load data
//   fault, fault_cause    one-cycle fault pulse, 01 misaligned/10 bus/11 illegal
// ---------------------------------------------------------------------------
module lsu #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_t;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseMisalign = 2'b01;
  localparam logic [1:0] CauseBus      = 2'b10;
  localparam logic [1:0] CauseIllegal  = 2'b11;

  state_t      state_q, state_d;
  logic        readyEn_q;

  logic        isLoad_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;

  logic        memWe_q;
  logic [31:0] memAddr_q;
  logic [3:0]  memWstrb_q;
  logic [31:0] memWdata_q;

  logic        wbValid_q, wbValid_d;
  logic [4:0]  wbRd_q, wbRd_d;
  logic [31:0] wbData_q, wbData_d;
  logic        fault_q, fault_d;
  logic [1:0]  faultCause_q, faultCause_d;

  logic        accept;
  logic        illegalOp;
  logic        misalignedOp;
  logic [1:0]  acceptCause;
  logic [3:0]  storeStrb;
  logic [31:0] storeData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;
  logic        timeoutHit;

  // ex_ready is held low through reset and only opens on the first clock
  // edge after rst_n deasserts, so nothing can be accepted in that window.
  assign ex_ready = (state_q == StIdle) && readyEn_q;
  assign accept   = ex_valid && ex_ready && (is_load || is_store);

  // Decode the incoming op: illegal encodings first, then alignment. Illegal
  // wins when both apply.
  always_comb begin
    illegalOp    = 1'b0;
    misalignedOp = 1'b0;
    if (is_load && is_store) begin
      illegalOp = 1'b1;
    end else if (is_load) begin
      illegalOp = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (is_store) begin
      illegalOp = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end
    if (funct3[1:0] == 2'b01) begin
      misalignedOp = addr[0];
    end else if (funct3[1:0] == 2'b10) begin
      misalignedOp = (addr[1:0] != 2'b00);
    end
    if (illegalOp) begin
      acceptCause = CauseIllegal;
    end else if (misalignedOp) begin
      acceptCause = CauseMisalign;
    end else begin
      acceptCause = CauseNone;
    end
  end

  // Byte enables and lane-replicated store data. Replicating the data means
  // the slave can pick up the right bytes using only the strobes.
  always_comb begin
    storeStrb = 4'b0000;
    storeData = wdata;
    case (funct3[1:0])
      2'b00: begin
        storeStrb = 4'b0001 << addr[1:0];
        storeData = {4{wdata[7:0]}};
      end
      2'b01: begin
        storeStrb = 4'b0011 << addr[1:0];
        storeData = {2{wdata[15:0]}};
      end
      default: begin
        storeStrb = 4'b1111;
        storeData = wdata;
      end
    endcase
    if (!is_store) begin
      storeStrb = 4'b0000;
    end
  end

  // Pull the addressed lane out of the read word and extend it according to
  // the latched funct3 (bit 2 set means zero-extend).
  assign loadByte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign loadHalf = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    loadData = mem_rdata;
    case (funct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadData = {24'd0, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW        = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int unsigned WaitLastInt = (WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0;
  localparam logic [CntW-1:0] WaitLast = WaitLastInt[CntW-1:0];

  logic [CntW-1:0] waitCnt_q;

  // Counts REQ cycles without an ack. It is cleared whenever REQ is entered
  // and never runs past WaitLast because the FSM leaves REQ at that point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_q <= '0;
    end else if (state_q != StReq) begin
      waitCnt_q <= '0;
    end else if (!mem_ack) begin
      waitCnt_q <= waitCnt_q + CntW'(1);
    end
  end

  assign timeoutHit = (WAIT_MAX != 0) && (state_q == StReq) && !mem_ack &&
                      (waitCnt_q == WaitLast);
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state and registered-output decisions. Pulses default to zero so
  // they last exactly one cycle; writeback data/rd hold their last value.
  always_comb begin
    state_d      = state_q;
    wbValid_d    = 1'b0;
    wbRd_d       = wbRd_q;
    wbData_d     = wbData_q;
    fault_d      = 1'b0;
    faultCause_d = CauseNone;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (acceptCause != CauseNone) begin
            state_d      = StDone;
            fault_d      = 1'b1;
            faultCause_d = acceptCause;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ack) begin
          state_d = StDone;
          if (mem_err) begin
            fault_d      = 1'b1;
            faultCause_d = CauseBus;
          end else if (isLoad_q) begin
            wbValid_d = 1'b1;
            wbRd_d    = rd_q;
            wbData_d  = loadData;
          end
        end else if (timeoutHit) begin
          state_d      = StDone;
          fault_d      = 1'b1;
          faultCause_d = CauseBus;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register plus the reset-release flag that gates ex_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      readyEn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      readyEn_q <= 1'b1;
    end
  end

  // Latch the op context and bus fields at accept; the bus registers are
  // untouched during REQ, which keeps every bus output stable until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isLoad_q   <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      rd_q       <= 5'd0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 32'd0;
      memWstrb_q <= 4'b0000;
      memWdata_q <= 32'd0;
    end else if (accept) begin
      isLoad_q <= is_load;
      funct3_q <= funct3;
      lane_q   <= addr[1:0];
      rd_q     <= rd;
      if (acceptCause == CauseNone) begin
        memWe_q    <= is_store;
        memAddr_q  <= {addr[31:2], 2'b00};
        memWstrb_q <= storeStrb;
        memWdata_q <= storeData;
      end
    end
  end

  // Writeback and fault outputs are registered so they appear in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid_q    <= 1'b0;
      wbRd_q       <= 5'd0;
      wbData_q     <= 32'd0;
      fault_q      <= 1'b0;
      faultCause_q <= CauseNone;
    end else begin
      wbValid_q    <= wbValid_d;
      wbRd_q       <= wbRd_d;
      wbData_q     <= wbData_d;
      fault_q      <= fault_d;
      faultCause_q <= faultCause_d;
    end
  end

  // Write enable and strobes are qualified by mem_req so the bus never sees
  // a stale write intent outside a transaction.
  assign mem_req     = (state_q == StReq);
  assign mem_we      = memWe_q && mem_req;
  assign mem_wstrb   = mem_req ? memWstrb_q : 4'b0000;
  assign mem_addr    = memAddr_q;
  assign mem_wdata   = memWdata_q;
  assign wb_valid    = wbValid_q;
  assign wb_rd       = wbRd_q;
  assign wb_data     = wbData_q;
  assign fault       = fault_q;
  assign fault_cause = faultCause_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. Directed cases followed by random
// ops, each compared against a byte/size arithmetic model of the LSU rules.
// ---------------------------------------------------------------------------
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [1:0]  fault_cause;

  int testsRun;
  int testsFailed;

  lsu #(.WAIT_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rd         (rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_err    (mem_err),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: a hung handshake still produces a FAIL line and ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Size in bytes of the access selected by funct3.
  function automatic int accessSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Expected fault cause for an accepted op (0 means no fault).
  function automatic logic [1:0] modelCause(input bit ld, input bit st,
                                            input logic [2:0] f3,
                                            input logic [31:0] a);
    bit legal;
    if (ld && st) return 2'b11;
    if (ld) legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2});
    if (!legal) return 2'b11;
    if ((int'(a[1:0]) % accessSize(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  // Expected byte enables: a run of size ones starting at the byte offset.
  function automatic logic [3:0] modelStrb(input bit st, input logic [2:0] f3,
                                           input logic [31:0] a);
    int run;
    if (!st) return 4'b0000;
    run = ((1 << accessSize(f3)) - 1) << int'(a[1:0]);
    return 4'(run);
  endfunction

  // Expected bus write data: the store value copied into every lane.
  function automatic logic [31:0] modelWdata(input logic [2:0] f3,
                                             input logic [31:0] wd);
    case (accessSize(f3))
      1:       return {24'd0, wd[7:0]} * 32'h01010101;
      2:       return {16'd0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  // Expected load result: shift the addressed bytes down, mask, extend.
  function automatic logic [31:0] modelLoad(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] rdat);
    int          size;
    logic [31:0] mask;
    logic [31:0] val;
    size = accessSize(f3);
    mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    val  = (rdat >> (8 * int'(a[1:0]))) & mask;
    if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | ~mask;
    return val;
  endfunction

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present an op on the execute-side inputs.
  task automatic applyStimulus(input bit v, input bit ld, input bit st,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [4:0] r);
    ex_valid = v;
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    rd       = r;
  endtask

  // Run one accepted op end to end, acknowledging after 'waits' idle REQ
  // cycles, and check every cycle against the model.
  task automatic runOp(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] r, input int waits, input bit err,
                       input logic [31:0] rdat);
    logic [1:0] cause;
    cause = modelCause(ld, st, f3, a);
    @(negedge clk);
    checkOutput("ex_ready before accept", 32'(ex_ready), 32'd1);
    applyStimulus(1'b1, ld, st, f3, a, wd, r);
    @(negedge clk);
    ex_valid = 1'b0;
    if (cause != 2'b00) begin
      checkOutput("accept fault pulse", 32'(fault), 32'd1);
      checkOutput("accept fault cause", 32'(fault_cause), 32'(cause));
      checkOutput("no mem_req on fault", 32'(mem_req), 32'd0);
      checkOutput("no wb on fault", 32'(wb_valid), 32'd0);
      checkOutput("ex_ready low in done", 32'(ex_ready), 32'd0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        checkOutput("mem_req in req", 32'(mem_req), 32'd1);
        checkOutput("mem_addr", mem_addr, {a[31:2], 2'b00});
        checkOutput("mem_we", 32'(mem_we), 32'(st));
        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(modelStrb(st, f3, a)));
        if (st) checkOutput("mem_wdata", mem_wdata, modelWdata(f3, wd));
        checkOutput("ex_ready low in req", 32'(ex_ready), 32'd0);
        checkOutput("no pulse in req", 32'({wb_valid, fault}), 32'd0);
        if (w == waits) begin
          mem_ack   = 1'b1;
          mem_err   = err;
          mem_rdata = rdat;
        end else begin
          mem_ack   = 1'b0;
          mem_err   = 1'($urandom);
          mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_err = 1'b0;
      end
      checkOutput("mem_req low in done", 32'(mem_req), 32'd0);
      if (err) begin
        checkOutput("bus fault pulse", 32'(fault), 32'd1);
        checkOutput("bus fault cause", 32'(fault_cause), 32'd2);
        checkOutput("no wb on bus fault", 32'(wb_valid), 32'd0);
      end else if (ld) begin
        checkOutput("wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("wb_rd", 32'(wb_rd), 32'(r));
        checkOutput("wb_data", wb_data, modelLoad(f3, a, rdat));
        checkOutput("no fault on load", 32'(fault), 32'd0);
      end else begin
        checkOutput("no wb on store", 32'(wb_valid), 32'd0);
        checkOutput("no fault on store", 32'(fault), 32'd0);
      end
    end
    @(negedge clk);
    checkOutput("ex_ready after done", 32'(ex_ready), 32'd1);
    checkOutput("pulses cleared", 32'({wb_valid, fault, fault_cause}), 32'd0);
  endtask

  initial begin
    int kind;
    logic [2:0] f3;
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    mem_ack     = 1'b0;
    mem_err     = 1'b0;
    mem_rdata   = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);

    // Reset values.
    #12;
    checkOutput("reset ex_ready", 32'(ex_ready), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("reset wb_data", wb_data, 32'd0);
    checkOutput("reset fault", 32'({fault, fault_cause}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ex_ready before first edge", 32'(ex_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("ex_ready after first edge", 32'(ex_ready), 32'd1);

    // Directed cases.
    runOp(1'b1, 1'b0, 3'b010, 32'h00001004, 32'd0, 5'd7, 0, 1'b0, 32'hDEADBEEF);
    runOp(1'b1, 1'b0, 3'b000, 32'h00002003, 32'd0, 5'd8, 0, 1'b0, 32'h80FFFFFF);
    runOp(1'b1, 1'b0, 3'b100, 32'h00002003, 32'd0, 5'd9, 1, 1'b0, 32'h80FFFFFF);
    runOp(1'b0, 1'b1, 3'b001, 32'h00003002, 32'h1234ABCD, 5'd0, 3, 1'b0, 32'd0);
    runOp(1'b1, 1'b0, 3'b010, 32'h00004001, 32'd0, 5'd1, 0, 1'b0, 32'd0);
    runOp(1'b0, 1'b1, 3'b011, 32'h00004000, 32'h55, 5'd0, 0, 1'b0, 32'd0);
    runOp(1'b1, 1'b1, 3'b000, 32'h00004000, 32'h55, 5'd2, 0, 1'b0, 32'd0);
    runOp(1'b1, 1'b0, 3'b001, 32'h00005002, 32'd0, 5'd4, 2, 1'b1, 32'h12345678);
    runOp(1'b1, 1'b0, 3'b101, 32'h00005002, 32'd0, 5'd0, 0, 1'b0, 32'hF00D0000);

    // An op with neither load nor store is ignored; a stray ack in IDLE too.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h6000, 32'd0, 5'd3);
    mem_ack = 1'b1;
    @(negedge clk);
    checkOutput("ignored op mem_req", 32'(mem_req), 32'd0);
    checkOutput("ignored op ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("ignored op pulses", 32'({wb_valid, fault}), 32'd0);
    ex_valid = 1'b0;
    mem_ack  = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // No ack ever: REQ lasts WAIT_MAX (4) cycles, then a bus fault.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h7000, 32'd0, 5'd3);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput("timeout req held", 32'(mem_req), 32'd1);
      @(negedge clk);
    end
    checkOutput("timeout req dropped", 32'(mem_req), 32'd0);
    checkOutput("timeout fault", 32'({fault, fault_cause}), 32'b110);
    checkOutput("timeout no wb", 32'(wb_valid), 32'd0);
    @(negedge clk);
    checkOutput("timeout ex_ready", 32'(ex_ready), 32'd1);
`endif

    // Reset in the middle of REQ abandons the transaction at once.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h8000, 32'd0, 5'd5);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("pre-reset mem_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("async reset ex_ready", 32'(ex_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post-reset idle", 32'({ex_ready, mem_req}), 32'b10);

    // Random ops against the model.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) != 0) begin
        f3 = (kind < 5) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2));
        if (f3 == 3'd3) f3 = 3'd4;
      end else begin
        f3 = 3'($urandom);
      end
      if (kind == 9) begin
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, f3, $urandom, $urandom, 5'($urandom));
        @(negedge clk);
        checkOutput("random ignored op", 32'({mem_req, fault, ex_ready}), 32'b001);
        ex_valid = 1'b0;
      end else begin
        runOp(kind < 5 || kind == 8, kind >= 5, f3, $urandom, $urandom,
              5'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
              $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
